// File: rtl/sched_pkg.sv
// Shared types and helpers for the single-iteration iSLIP VOQ scheduler.
package sched_pkg;

   localparam int DEF_EGRESS_CNT = 4;
   localparam int DEF_SEL_W      = $clog2(DEF_EGRESS_CNT);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      ACCEPT,
      SLOT
   } sched_state_t;

   // Bit offset of select field idx inside a packed array of selW-wide fields.
   function automatic int sel_field(input int idx, input int selW);
      return idx * selW;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter
   import sched_pkg::*;
#(
   parameter int N     = DEF_EGRESS_CNT,
   parameter int SEL_W = DEF_SEL_W
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [SEL_W-1:0] idx,
   output logic             vld
);

   logic [SEL_W-1:0] cand;

   // N is a power of two, so ptr+k wraps modulo N for free in SEL_W bits.
   always_comb begin
      gnt  = '0;
      idx  = '0;
      vld  = 1'b0;
      cand = '0;
      for (int k = 0; k < N; k++) begin
         cand = ptr + SEL_W'(k);
         if (!vld && req[cand]) begin
            vld       = 1'b1;
            idx       = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/voq_scheduler.sv
// Single-iteration iSLIP scheduler: grant, accept, then hold a permutation for one packet slot.
module voq_scheduler
   import sched_pkg::*;
#(
   parameter  int EGRESS_CNT = DEF_EGRESS_CNT,
   parameter  int PKT_CYCLES = 8,
   localparam int SEL_W      = $clog2(EGRESS_CNT)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             sched_en,
   input  logic [EGRESS_CNT*EGRESS_CNT-1:0] voq_nonempty,
   output logic [SEL_W*EGRESS_CNT-1:0]      sched_sel,
   output logic [EGRESS_CNT-1:0]            match_valid,
   output logic                             slot_start,
   output logic                             busy
);

   localparam int N     = EGRESS_CNT;
   localparam int CNT_W = $clog2(PKT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_CYCLES - 1);

   sched_state_t            state, stateNext;
   logic [CNT_W-1:0]        slotCnt;
   logic [N-1:0][SEL_W-1:0] grantPtr, acceptPtr;

   logic [N-1:0][N-1:0]     colReq;
   logic [N-1:0][N-1:0]     gGnt;
   logic [N-1:0][SEL_W-1:0] gIdx;
   logic [N-1:0]            gVld;
   logic [N-1:0][N-1:0]     grantReg;

   logic [N-1:0][N-1:0]     aReq;
   logic [N-1:0][N-1:0]     aGnt;
   logic [N-1:0][SEL_W-1:0] aIdx;
   logic [N-1:0]            aVld;

   logic [N-1:0]            used;
   logic                    placed;
   logic [SEL_W*N-1:0]      selNext;
   logic                    reqAny, slotLast;
   logic                    unusedGrantIdx;

   assign reqAny         = sched_en && (|voq_nonempty);
   assign slotLast       = (slotCnt == LAST_CNT);
   assign busy           = (state != IDLE);
   assign unusedGrantIdx = ^gIdx;

   // colReq[j] is egress j's view of the requests; aReq[i] is ingress i's view of the grants.
   always_comb begin
      colReq = '0;
      aReq   = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            colReq[j][i] = voq_nonempty[i*N+j];
            aReq[i][j]   = grantReg[j][i];
         end
      end
   end

   for (genvar g = 0; g < N; g++) begin : gen_arb
      rr_arbiter #(.N(N), .SEL_W(SEL_W)) uGrant (
         .req (colReq[g]),
         .ptr (grantPtr[g]),
         .gnt (gGnt[g]),
         .idx (gIdx[g]),
         .vld (gVld[g])
      );
      rr_arbiter #(.N(N), .SEL_W(SEL_W)) uAccept (
         .req (aReq[g]),
         .ptr (acceptPtr[g]),
         .gnt (aGnt[g]),
         .idx (aIdx[g]),
         .vld (aVld[g])
      );
   end

   // Unmatched ingresses take the leftover egresses in ascending order so sched_sel stays a permutation.
   always_comb begin
      used    = '0;
      placed  = 1'b0;
      selNext = '0;
      for (int i = 0; i < N; i++) begin
         used = used | aGnt[i];
      end
      for (int i = 0; i < N; i++) begin
         placed = 1'b0;
         if (aVld[i]) begin
            selNext[sel_field(i, SEL_W) +: SEL_W] = aIdx[i];
         end else begin
            for (int e = 0; e < N; e++) begin
               if (!placed && !used[e]) begin
                  selNext[sel_field(i, SEL_W) +: SEL_W] = SEL_W'(e);
                  used[e] = 1'b1;
                  placed  = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (reqAny) stateNext = GRANT;
         GRANT:   stateNext = ACCEPT;
         ACCEPT:  stateNext = SLOT;
         SLOT:    if (slotLast) stateNext = reqAny ? GRANT : IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Grants are captured in GRANT; the matching and pointer moves are committed at the end of ACCEPT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slotCnt     <= '0;
         grantPtr    <= '0;
         acceptPtr   <= '0;
         grantReg    <= '0;
         match_valid <= '0;
         slot_start  <= 1'b0;
         for (int i = 0; i < N; i++) begin
            sched_sel[sel_field(i, SEL_W) +: SEL_W] <= SEL_W'(i);
         end
      end else begin
         slot_start <= (state == ACCEPT);
         if (state == SLOT) begin
            slotCnt <= slotLast ? '0 : slotCnt + CNT_W'(1);
         end
         if (state == GRANT) begin
            for (int j = 0; j < N; j++) begin
               grantReg[j] <= gVld[j] ? gGnt[j] : '0;
            end
         end
         if (state == ACCEPT) begin
            sched_sel   <= selNext;
            match_valid <= aVld;
            for (int i = 0; i < N; i++) begin
               if (aVld[i]) begin
                  grantPtr[aIdx[i]] <= SEL_W'(i) + SEL_W'(1);
                  acceptPtr[i]      <= aIdx[i] + SEL_W'(1);
               end
            end
         end else if (state == SLOT && slotLast) begin
            match_valid <= '0;
         end
      end
   end

endmodule

// File: tb/tb_voq_scheduler.sv
// Directed plus randomized bench for voq_scheduler against an iSLIP reference model.
module tb_voq_scheduler;

   localparam int N   = 4;
   localparam int PKT = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sched_en;
   logic [15:0] voq_nonempty;
   logic [7:0]  sched_sel;
   logic [3:0]  match_valid;
   logic        slot_start;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int cycleNo = 0;
   int lastStart = 0;

   int         gp[N];
   int         ap[N];
   logic [7:0] expSel;
   logic [3:0] expMv;
   logic [15:0] cur, nxt;

   voq_scheduler #(.EGRESS_CNT(N), .PKT_CYCLES(PKT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sched_en     (sched_en),
      .voq_nonempty (voq_nonempty),
      .sched_sel    (sched_sel),
      .match_valid  (match_valid),
      .slot_start   (slot_start),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleNo <= cycleNo + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [15:0] req);
      sched_en     = en;
      voq_nonempty = req;
   endtask

   task automatic resetModel();
      for (int k = 0; k < N; k++) begin
         gp[k] = 0;
         ap[k] = 0;
      end
      expSel = 8'hE4;
      expMv  = 4'b0000;
   endtask

   function automatic bit isPerm(input logic [7:0] sel);
      logic [3:0] seen;
      seen = 4'b0000;
      for (int i = 0; i < N; i++) seen[sel[2*i +: 2]] = 1'b1;
      return (seen == 4'hF);
   endfunction

   // One iSLIP iteration on the request matrix, then fill and pointer moves.
   task automatic modelSlot(input logic [15:0] req);
      int grantTo[N];
      int acc[N];
      bit egUsed[N];
      int fld[N];
      for (int j = 0; j < N; j++) begin
         grantTo[j] = -1;
         for (int k = 0; k < N; k++) begin
            int i;
            i = (gp[j] + k) % N;
            if (grantTo[j] < 0 && req[i*N+j]) grantTo[j] = i;
         end
      end
      for (int i = 0; i < N; i++) begin
         acc[i] = -1;
         egUsed[i] = 1'b0;
         for (int k = 0; k < N; k++) begin
            int j;
            j = (ap[i] + k) % N;
            if (acc[i] < 0 && grantTo[j] == i) acc[i] = j;
         end
      end
      expMv = 4'b0000;
      for (int i = 0; i < N; i++) begin
         if (acc[i] >= 0) begin
            expMv[i]       = 1'b1;
            egUsed[acc[i]] = 1'b1;
            fld[i]         = acc[i];
            gp[acc[i]]     = (i + 1) % N;
            ap[i]          = (acc[i] + 1) % N;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (acc[i] < 0) begin
            for (int e = N - 1; e >= 0; e--) if (!egUsed[e]) fld[i] = e;
            egUsed[fld[i]] = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) expSel[2*i +: 2] = 2'(fld[i]);
   endtask

   task automatic waitStart(input string tag, input int expLat);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!slot_start && n < 20);
      checkOutput(tag, n, expLat);
      lastStart = cycleNo;
   endtask

   // Entered on the negedge of the first SLOT cycle; leaves on the negedge of the last one.
   task automatic runSlot(input logic [15:0] req, input logic [15:0] nextReq, input bit dropEn);
      modelSlot(req);
      checkOutput("perm", isPerm(sched_sel), 1);
      for (int c = 1; c <= PKT; c++) begin
         if (c > 1) @(negedge clk);
         checkOutput($sformatf("slot_mv_c%0d", c), match_valid, expMv);
         checkOutput($sformatf("slot_sel_c%0d", c), sched_sel, expSel);
         checkOutput($sformatf("slot_busy_c%0d", c), busy, 1);
         checkOutput($sformatf("slot_start_c%0d", c), slot_start, (c == 1));
         if (dropEn && c == 2) sched_en = 1'b0;
         voq_nonempty = (c == PKT) ? nextReq : 16'($urandom);
      end
   endtask

   task automatic gapCheck();
      for (int g = 1; g <= 2; g++) begin
         @(negedge clk);
         checkOutput("gap_mv", match_valid, 0);
         checkOutput("gap_busy", busy, 1);
         checkOutput("gap_start", slot_start, 0);
         checkOutput("gap_sel_hold", sched_sel, expSel);
      end
      @(negedge clk);
      checkOutput("gap_next_start", slot_start, 1);
      checkOutput("start_spacing", cycleNo - lastStart, 10);
      lastStart = cycleNo;
   endtask

   task automatic idleCheck();
      for (int g = 0; g < 4; g++) begin
         @(negedge clk);
         checkOutput("idle_busy", busy, 0);
         checkOutput("idle_mv", match_valid, 0);
         checkOutput("idle_start", slot_start, 0);
         checkOutput("idle_sel_hold", sched_sel, expSel);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 16'h0000);
      resetModel();
      repeat (2) @(negedge clk);
      checkOutput("rst_sel", sched_sel, 8'hE4);
      checkOutput("rst_mv", match_valid, 0);
      checkOutput("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_sel", sched_sel, 8'hE4);
      checkOutput("post_rst_busy", busy, 0);
      checkOutput("post_rst_start", slot_start, 0);

      // Single request: ingress 2 -> egress 1.
      applyStimulus(1'b1, 16'h0200);
      waitStart("single_latency", 3);
      checkOutput("single_mv", match_valid, 4'b0100);
      checkOutput("single_sel", sched_sel, 8'hD8);
      runSlot(16'h0200, 16'h0000, 1'b0);
      idleCheck();

      // Contention: ingresses 0 and 1 both want egress 3.
      applyStimulus(1'b1, 16'h0088);
      waitStart("contend_latency", 3);
      for (int s = 0; s < 4; s++) begin
         logic [1:0] fld;
         fld = sched_sel[2*(s%2) +: 2];
         checkOutput($sformatf("contend_mv_s%0d", s), match_valid, 4'(1 << (s % 2)));
         checkOutput($sformatf("contend_field_s%0d", s), fld, 2'd3);
         runSlot(16'h0088, (s == 3) ? 16'h0000 : 16'h0088, 1'b0);
         if (s == 3) idleCheck();
         else gapCheck();
      end

      // Asynchronous reset in the middle of a slot.
      applyStimulus(1'b1, 16'hFFFF);
      waitStart("midrst_latency", 3);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_sel", sched_sel, 8'hE4);
      checkOutput("midrst_mv", match_valid, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_start", slot_start, 0);
      resetModel();
      voq_nonempty = 16'h0000;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("midrst_release_busy", busy, 0);

      // Full load from fresh pointers, ending with an enable drop in the last slot.
      applyStimulus(1'b1, 16'hFFFF);
      waitStart("full_latency", 3);
      for (int s = 1; s <= 6; s++) begin
         if (s == 1) checkOutput("full_s1_mv", match_valid, 4'b0001);
         if (s == 2) checkOutput("full_s2_count", $countones(match_valid), 2);
         if (s >= 4) checkOutput($sformatf("full_s%0d_mv", s), match_valid, 4'b1111);
         runSlot(16'hFFFF, 16'hFFFF, (s == 6));
         if (s == 6) idleCheck();
         else gapCheck();
      end

      // Randomized request matrices with occasional idle periods.
      sched_en = 1'b1;
      cur = 16'($urandom) | (16'h1 << $urandom_range(0, 15));
      voq_nonempty = cur;
      waitStart("rand_latency", 3);
      for (int s = 0; s < 14; s++) begin
         if (s == 13 || $urandom_range(0, 4) == 0) nxt = 16'h0000;
         else if ($urandom_range(0, 1) == 0) nxt = 16'($urandom & $urandom) | (16'h1 << $urandom_range(0, 15));
         else nxt = 16'($urandom) | (16'h1 << $urandom_range(0, 15));
         runSlot(cur, nxt, 1'b0);
         if (nxt == 16'h0000) begin
            idleCheck();
            if (s != 13) begin
               cur = 16'($urandom) | (16'h1 << $urandom_range(0, 15));
               voq_nonempty = cur;
               waitStart("rand_restart_latency", 3);
            end
         end else begin
            gapCheck();
            cur = nxt;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
